montgomery_exp_ctrl: RTL and testbench

Left-to-right square-and-multiply sequencer for modular exponentiation, result = base^exponent mod m. It sits directly upstream of the Montgomery multiplier. It issues one multiply at a time over the mm_* port group, consumes each product, and performs the final conversion out of the Montgomery domain. The host supplies base_mont = base·2^k mod m and one_mont = 2^k mod m, where k = m_size.

---
 rtl/montgomery_exp_ctrl_pkg.sv | 33 +++
 rtl/montgomery_exp_ctrl_if.sv | 31 +++
 rtl/montgomery_exp_ctrl.sv | 148 ++++++++++++++
 tb/tb_montgomery_exp_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_exp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// montgomery_pkg : shared state encoding and widths for montgomery_exp_ctrl
// Revision 1.0
// ============================================================================
package montgomery_pkg;

  localparam int M_SIZE_W      = 12;
  localparam int NBITS_DEFAULT = 2048;
  localparam int EBITS_DEFAULT = 2048;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SQR_ISSUE  = 3'd1;
  localparam logic [2:0] ST_SQR_WAIT   = 3'd2;
  localparam logic [2:0] ST_MUL_ISSUE  = 3'd3;
  localparam logic [2:0] ST_MUL_WAIT   = 3'd4;
  localparam logic [2:0] ST_CONV_ISSUE = 3'd5;
  localparam logic [2:0] ST_CONV_WAIT  = 3'd6;
  localparam logic [2:0] ST_DONE       = 3'd7;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    SQR_ISSUE  = ST_SQR_ISSUE,
    SQR_WAIT   = ST_SQR_WAIT,
    MUL_ISSUE  = ST_MUL_ISSUE,
    MUL_WAIT   = ST_MUL_WAIT,
    CONV_ISSUE = ST_CONV_ISSUE,
    CONV_WAIT  = ST_CONV_WAIT,
    DONE       = ST_DONE
  } state_e;

endpackage
`default_nettype wire

// File: rtl/montgomery_exp_ctrl_if.sv
`default_nettype none
// ============================================================================
// montgomery_exp_ctrl_if : launch/operand/product group to the Montgomery multiplier
// Revision 1.0
// ============================================================================
interface montgomery_exp_ctrl_if
  import montgomery_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
);

  logic                mm_enable_p;
  logic [NBITS-1:0]    mm_a;
  logic [NBITS-1:0]    mm_b;
  logic [NBITS-1:0]    mm_m;
  logic [M_SIZE_W-1:0] mm_m_size;
  logic [NBITS-1:0]    mm_y;
  logic                mm_done_irq_p;

  modport master (
    output mm_enable_p, mm_a, mm_b, mm_m, mm_m_size,
    input  mm_y, mm_done_irq_p
  );

  modport slave (
    input  mm_enable_p, mm_a, mm_b, mm_m, mm_m_size,
    output mm_y, mm_done_irq_p
  );

endinterface
`default_nettype wire

// File: rtl/montgomery_exp_ctrl.sv
`default_nettype none
// ============================================================================
// montgomery_exp_ctrl : left-to-right square-and-multiply sequencer driving a
// Montgomery multiplier, with final conversion out of the Montgomery domain.
// Revision 1.0
// ============================================================================
module montgomery_exp_ctrl
  import montgomery_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT,
  parameter int EBITS = EBITS_DEFAULT
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                start_p,
  input  wire logic [NBITS-1:0]    base_mont,
  input  wire logic [NBITS-1:0]    one_mont,
  input  wire logic [EBITS-1:0]    exponent,
  input  wire logic [M_SIZE_W-1:0] e_size,
  input  wire logic [NBITS-1:0]    m,
  input  wire logic [M_SIZE_W-1:0] m_size,
  montgomery_exp_ctrl_if.master    mm,
  output logic      [NBITS-1:0]    result,
  output logic                     busy,
  output logic                     done_irq_p
);

  state_e              state_q, state_d;
  logic [NBITS-1:0]    acc_q, acc_d;
  logic [NBITS-1:0]    base_q, base_d;
  logic [EBITS-1:0]    e_q, e_d;
  logic [M_SIZE_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0]    a_q, a_d;
  logic [NBITS-1:0]    b_q, b_d;
  logic [NBITS-1:0]    result_q, result_d;

  logic [M_SIZE_W-1:0] idx_m1;
  logic [M_SIZE_W-1:0] esize_clamped;
  logic                ebit;

  assign idx_m1        = idx_q - 1'b1;
  assign esize_clamped = (e_size > M_SIZE_W'(EBITS)) ? M_SIZE_W'(EBITS) : e_size;
  assign ebit          = |(e_q & (EBITS'(1) << idx_m1));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    e_d      = e_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start_p) begin
          acc_d   = one_mont;
          base_d  = base_mont;
          e_d     = exponent;
          idx_d   = esize_clamped;
          state_d = (esize_clamped == '0) ? CONV_ISSUE : SQR_ISSUE;
        end
      end
      SQR_ISSUE: state_d = SQR_WAIT;
      SQR_WAIT: begin
        if (mm.mm_done_irq_p) begin
          acc_d = mm.mm_y;
          idx_d = idx_m1;
          if (ebit)                state_d = MUL_ISSUE;
          else if (idx_m1 == '0)   state_d = CONV_ISSUE;
          else                     state_d = SQR_ISSUE;
        end
      end
      MUL_ISSUE: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mm.mm_done_irq_p) begin
          acc_d   = mm.mm_y;
          state_d = (idx_q == '0) ? CONV_ISSUE : SQR_ISSUE;
        end
      end
      CONV_ISSUE: state_d = CONV_WAIT;
      CONV_WAIT: begin
        if (mm.mm_done_irq_p) begin
          result_d = mm.mm_y;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Operands are loaded from the updated accumulator on entry to each
    // ISSUE state, so they are stable for the whole ISSUE/WAIT pair.
    if (state_d != state_q) begin
      unique case (state_d)
        SQR_ISSUE: begin
          a_d = acc_d;
          b_d = acc_d;
        end
        MUL_ISSUE: begin
          a_d = acc_d;
          b_d = base_d;
        end
        CONV_ISSUE: begin
          a_d = acc_d;
          b_d = NBITS'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      e_q      <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      e_q      <= e_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign mm.mm_enable_p = (state_q == SQR_ISSUE) || (state_q == MUL_ISSUE) ||
                          (state_q == CONV_ISSUE);
  assign mm.mm_a        = a_q;
  assign mm.mm_b        = b_q;
  assign mm.mm_m        = m;
  assign mm.mm_m_size   = m_size;

  assign result     = result_q;
  assign busy       = (state_q != IDLE);
  assign done_irq_p = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_montgomery_exp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_montgomery_exp_ctrl : scoreboard bench with a behavioural Montgomery multiplier
// Revision 1.0
// ============================================================================
module tb_montgomery_exp_ctrl;
  import montgomery_pkg::*;

  localparam int NB = 8;
  localparam int EB = 8;

  logic                clk;
  logic                rst_n;
  logic                start_p;
  logic [NB-1:0]       base_mont;
  logic [NB-1:0]       one_mont;
  logic [EB-1:0]       exponent;
  logic [M_SIZE_W-1:0] e_size;
  logic [NB-1:0]       m;
  logic [M_SIZE_W-1:0] m_size;
  logic [NB-1:0]       result;
  logic                busy;
  logic                done_irq_p;

  montgomery_exp_ctrl_if #(.NBITS(NB)) mm_if ();

  montgomery_exp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_p    (start_p),
    .base_mont  (base_mont),
    .one_mont   (one_mont),
    .exponent   (exponent),
    .e_size     (e_size),
    .m          (m),
    .m_size     (m_size),
    .mm         (mm_if),
    .result     (result),
    .busy       (busy),
    .done_irq_p (done_irq_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference Montgomery product a*b*2^-k mod n, bit-serial reduction.
  function automatic int mont(input int a, input int b, input int n, input int k);
    int t;
    t = a * b;
    for (int i = 0; i < k; i++) begin
      if (t[0]) t = t + n;
      t = t >> 1;
    end
    if (t >= n) t = t - n;
    return t;
  endfunction

  function automatic int powmod(input int b, input int e, input int n, input int mod);
    int r, x;
    r = 1 % mod;
    x = b % mod;
    for (int i = 0; i < n; i++) begin
      if (e[i]) r = (r * x) % mod;
      x = (x * x) % mod;
    end
    return r;
  endfunction

  // Behavioural multiplier with variable latency.
  logic [NB-1:0] mdl_y;
  logic          mdl_done;
  logic          stray_done;
  logic [NB-1:0] pa, pb;
  int            lat_cnt;
  logic          pend;

  assign mm_if.mm_y          = mdl_y;
  assign mm_if.mm_done_irq_p = mdl_done | stray_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_done <= 1'b0;
      mdl_y    <= '0;
      pend     <= 1'b0;
      lat_cnt  <= 0;
      pa       <= '0;
      pb       <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (mm_if.mm_enable_p) begin
        pa      <= mm_if.mm_a;
        pb      <= mm_if.mm_b;
        lat_cnt <= int'($urandom_range(1, 4));
        pend    <= 1'b1;
      end else if (pend) begin
        if (lat_cnt <= 1) begin
          mdl_y    <= NB'(mont(int'(pa), int'(pb), int'(mm_if.mm_m), int'(mm_if.mm_m_size)));
          mdl_done <= 1'b1;
          pend     <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  int pulse_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 pulse_cnt <= 0;
    else if (start_p && !busy)  pulse_cnt <= 0;
    else if (mm_if.mm_enable_p) pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    int res;
    int pulses;
  } exp_t;
  exp_t sb_q[$];

  logic [NB-1:0] cap_a, cap_b;

  // Monitor: operand stability per multiply and job completion checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mm_if.mm_enable_p) begin
        cap_a = mm_if.mm_a;
        cap_b = mm_if.mm_b;
      end
      if (mdl_done) begin
        check("mm_a_stable", int'(mm_if.mm_a), int'(cap_a));
        check("mm_b_stable", int'(mm_if.mm_b), int'(cap_b));
      end
      if (done_irq_p) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", int'(result), e.res);
          check("pulses", pulse_cnt, e.pulses);
          check("busy_at_done", int'(busy), 1);
        end
      end
    end
  end

  task automatic start_job(input int bm, input int om, input int ex, input int es,
                           input int er, input int ep);
    exp_t e;
    @(negedge clk);
    base_mont = bm[NB-1:0];
    one_mont  = om[NB-1:0];
    exponent  = ex[EB-1:0];
    e_size    = es[M_SIZE_W-1:0];
    start_p   = 1'b1;
    e.res     = er;
    e.pulses  = ep;
    sb_q.push_back(e);
    @(negedge clk);
    start_p = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("job_timeout", 0, 1);
      rst_n = 1'b0;
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  task automatic run_job(input int bm, input int om, input int ex, input int es,
                         input int er, input int ep);
    start_job(bm, om, ex, es, er, ep);
    wait_idle();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rm, rb, re, res, om, bm, pc;
    rst_n     = 1'b0;
    start_p   = 1'b0;
    base_mont = '0;
    one_mont  = '0;
    exponent  = '0;
    e_size    = '0;
    m         = 8'd13;
    m_size    = 12'd4;
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_result", int'(result), 0);
    check("rst_done", int'(done_irq_p), 0);
    check("rst_enable", int'(mm_if.mm_enable_p), 0);
    check("rst_mm_a", int'(mm_if.mm_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // m=13, k=4, one_mont=3
    run_job(6, 3, 5, 3, 6, 6);
    run_job(6, 3, 8'hFF, 0, 1, 1);
    run_job(8, 3, 1, 1, 7, 3);
    run_job(6, 3, 12, 4, 1, 7);
    run_job(6, 3, 5, 12, 6, 11);

    // stray completion while idle
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_busy", int'(busy), 0);
    check("stray_result_hold", int'(result), 6);

    // second start while busy is ignored
    start_job(6, 3, 5, 3, 6, 6);
    repeat (4) @(negedge clk);
    base_mont = 8'd8;
    exponent  = 8'd1;
    e_size    = 12'd1;
    start_p   = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    wait_idle();

    // reset during SQR_WAIT
    start_job(6, 3, 12, 4, 1, 7);
    for (int i = 0; i < 50; i++) begin
      if (mm_if.mm_enable_p) break;
      @(negedge clk);
    end
    check("saw_first_issue", int'(mm_if.mm_enable_p), 1);
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_enable", int'(mm_if.mm_enable_p), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(8, 3, 1, 1, 7, 3);

    // random moduli with k=8
    m_size = 12'd8;
    for (int n = 0; n < 200; n++) begin
      rm = 2 * int'($urandom_range(4, 127)) + 1;
      rb = int'($urandom_range(0, rm - 1));
      re = int'($urandom_range(0, 255));
      res = int'($urandom_range(0, 8));
      om = 256 % rm;
      bm = (rb * 256) % rm;
      pc = res + 1;
      for (int i = 0; i < res; i++) pc += re[i];
      @(negedge clk);
      m = rm[NB-1:0];
      run_job(bm, om, re, res, powmod(rb, re, res, rm), pc);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
